hit_resolver: RTL and testbench
===============================

Name: hit_resolver

Overview:
- Consumer end of the collision path. Takes registered hit reports (detected flag, row, col) from the projectile/grid collision detector.
- Resolves each report against a 3x8 alive bitmap and retires the hit element.
- Kills the projectile, accumulates score and flags wave clear.
- Renderer reads element liveness through a query port; game FSM reads score and wave-clear.

Parameters:
GRID_ROWS, 3, number of element rows
GRID_COLS, 8, number of element columns
POINTS, 10, score added per kill
SCORE_W, 16, score width
EXPLODE_FRAMES, 8, frame ticks an explosion marker is held (used only with HIT_EXPLODE_EN)

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_collision_detected  in  1  collision flag from detector, level, registered upstream
i_hit_row  in  3  reported row
i_hit_col  in  4  reported column
i_obj1_active  in  1  projectile in flight
i_wave_reset  in  1  sync pulse: reload grid
i_score_clear  in  1  sync pulse: zero score
i_frame_tick  in  1  one-cycle pulse per video frame
i_query_row  in  3  render query row
i_query_col  in  4  render query column
o_query_alive  out  1  combinational alive bit at query coords; 0 if coords out of range
o_alive_mask  out  24  bit row*8+col = element alive
o_obj1_kill  out  1  one-cycle pulse: despawn projectile
o_hit_pulse  out  1  one-cycle pulse per confirmed kill
o_score  out  SCORE_W  accumulated score
o_wave_clear  out  1  all elements dead
o_explode_active  out  1  explosion marker valid (0 when feature off)
o_explode_row  out  3  explosion row
o_explode_col  out  4  explosion column

Behaviour:
Reset values:
- alive mask all ones (24'hFFFFFF); score 0.
- kill, hit_pulse, wave_clear, explode_active all 0; explode row/col 0.
- FSM in IDLE.

FSM (registered):
- IDLE: if i_collision_detected && i_obj1_active, latch row/col -> CHECK; else stay.
- CHECK: if latched row<GRID_ROWS, col<GRID_COLS and alive bit set -> KILL; else -> IDLE (hit on dead slot or out of range: no action, projectile continues).
- KILL: one cycle. Clear alive bit, score += POINTS (saturate at all-ones), o_obj1_kill=1, o_hit_pulse=1 -> WAIT_RELEASE.
- WAIT_RELEASE: ignore collisions until i_obj1_active==0 -> IDLE. Guarantees at most one kill per projectile.

Timing:
- Collision sampled high in cycle N -> kill/hit pulses high in cycle N+2 only.
- Mask bit and score updated at the end of N+2, visible from N+3.
- o_wave_clear is registered from the updated mask, high from N+4 on the last kill, held until i_wave_reset.

Reset and priority:
- i_wave_reset has top priority: mask to all ones, FSM to IDLE, wave_clear and explode cleared.
- An in-progress KILL coincident with wave_reset is dropped: no score, no pulses.
- i_score_clear zeroes score. If coincident with KILL, the result is 0 (clear wins). It does not affect mask or FSM.
- If i_obj1_active drops while in CHECK, resolution still completes (kill pulse harmless); FSM then returns through WAIT_RELEASE immediately.
- Asynchronous reset at any time returns all state to the reset values above.

Optional Feature:
HIT_EXPLODE_EN:
- Defined: on KILL, latch row/col into o_explode_row/col, set o_explode_active, and load a counter with EXPLODE_FRAMES. Decrement on each i_frame_tick; clear active at 0.
- A new kill while active restarts the counter with the new coords.
- Not defined: o_explode_active, o_explode_row and o_explode_col are tied 0 and no counter logic exists.

Test Plan:
- Reset, then query (2,7) -> o_query_alive=1, o_alive_mask=24'hFFFFFF, o_score=0, all pulses 0.
- Collision row=1 col=3 with active=1 in cycle N -> kill/hit high in N+2 only; mask bit 11 clear and score=10 from N+3.
- Hold collision row=1 col=3 high for 20 cycles with active=1 -> exactly one kill and score=10. Drop active, re-raise collision at the same (now dead) slot -> no kill.
- Collision at row=3 col=0 or row=0 col=9 -> no kill, mask unchanged, FSM back to IDLE.
- Kill all 24 elements in sequence -> score=240, o_wave_clear rises after the last kill. Pulse i_wave_reset -> mask FFFFFF and wave_clear 0 next cycle.
- With HIT_EXPLODE_EN and EXPLODE_FRAMES=8: kill at (0,5) -> explode_active=1, row=0, col=5. Active clears after the 8th i_frame_tick. Preset score to FFFF-5, then kill -> score saturates at FFFF.

Source files
------------

// File: rtl/hit_resolver.sv
// hit_resolver: consumer end of the projectile/grid collision path.
// Resolves registered hit reports against a GRID_ROWS x GRID_COLS alive
// bitmap, retires the hit element, despawns the projectile, accumulates a
// saturating score and flags wave clear once every element is dead.
//
// Ports:
//   i_clk, i_rst_n           clock, asynchronous active-low reset
//   i_collision_detected     level collision flag (registered upstream)
//   i_hit_row, i_hit_col     reported element coordinates
//   i_obj1_active            projectile in flight
//   i_wave_reset             sync pulse: reload grid, abort resolution
//   i_score_clear            sync pulse: zero score (wins over a kill)
//   i_frame_tick             one pulse per video frame (explosion timer)
//   i_query_row/col          render query coordinates
//   o_query_alive            combinational alive bit at query coords
//   o_alive_mask             bit row*GRID_COLS+col = element alive
//   o_obj1_kill, o_hit_pulse one-cycle pulse per confirmed kill
//   o_score                  accumulated score
//   o_wave_clear             all elements dead
//   o_explode_*              explosion marker (tied 0 unless HIT_EXPLODE_EN)
//
// Build option: define HIT_EXPLODE_EN to enable the explosion marker.
module hit_resolver #(
    parameter int unsigned GRID_ROWS      = 3,
    parameter int unsigned GRID_COLS      = 8,
    parameter int unsigned POINTS         = 10,
    parameter int unsigned SCORE_W        = 16,
    parameter int unsigned EXPLODE_FRAMES = 8
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_collision_detected,
    input  logic [2:0]                     i_hit_row,
    input  logic [3:0]                     i_hit_col,
    input  logic                           i_obj1_active,
    input  logic                           i_wave_reset,
    input  logic                           i_score_clear,
    input  logic                           i_frame_tick,
    input  logic [2:0]                     i_query_row,
    input  logic [3:0]                     i_query_col,
    output logic                           o_query_alive,
    output logic [GRID_ROWS*GRID_COLS-1:0] o_alive_mask,
    output logic                           o_obj1_kill,
    output logic                           o_hit_pulse,
    output logic [SCORE_W-1:0]             o_score,
    output logic                           o_wave_clear,
    output logic                           o_explode_active,
    output logic [2:0]                     o_explode_row,
    output logic [3:0]                     o_explode_col
);

    localparam int unsigned ROW_W = 3;
    localparam int unsigned COL_W = 4;
    localparam int unsigned CELLS = GRID_ROWS * GRID_COLS;
    localparam int unsigned IDX_W = $clog2(CELLS);
    localparam int unsigned SUM_W = SCORE_W + 1;

    typedef enum logic [1:0] {
        S_IDLE         = 2'd0,
        S_CHECK        = 2'd1,
        S_KILL         = 2'd2,
        S_WAIT_RELEASE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [ROW_W-1:0]     row_q;
    logic [COL_W-1:0]     col_q;
    logic [CELLS-1:0]     mask_q;
    logic [SCORE_W-1:0]   score_q;
    logic                 wave_clear_q;

    logic                 latch_c;
    logic                 kill_c;
    logic                 hit_valid_c;
    logic [IDX_W-1:0]     hit_idx_c;
    logic [IDX_W-1:0]     query_idx_c;
    logic [SUM_W-1:0]     score_sum_c;
    logic [SCORE_W-1:0]   score_inc_c;

    // Coordinates inside the grid
    function automatic logic in_range(input logic [ROW_W-1:0] r, input logic [COL_W-1:0] c);
        return (32'(r) < GRID_ROWS) && (32'(c) < GRID_COLS);
    endfunction

    // Flat bitmap index; only meaningful when in_range() holds
    function automatic logic [IDX_W-1:0] cell_idx(input logic [ROW_W-1:0] r, input logic [COL_W-1:0] c);
        return IDX_W'(IDX_W'(r) * IDX_W'(GRID_COLS) + IDX_W'(c));
    endfunction

    assign hit_idx_c   = cell_idx(row_q, col_q);
    assign hit_valid_c = in_range(row_q, col_q) && mask_q[hit_idx_c];

    // Render query: out-of-range coordinates read as dead
    assign query_idx_c   = cell_idx(i_query_row, i_query_col);
    assign o_query_alive = in_range(i_query_row, i_query_col) && mask_q[query_idx_c];

    // Saturating score increment
    assign score_sum_c = SUM_W'(score_q) + SUM_W'(POINTS);
    assign score_inc_c = score_sum_c[SCORE_W] ? '1 : score_sum_c[SCORE_W-1:0];

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and decoded strobes; wave reset overrides everything
    always_comb begin
        state_d = state_q;
        latch_c = 1'b0;
        kill_c  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_collision_detected && i_obj1_active) begin
                    latch_c = 1'b1;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                state_d = hit_valid_c ? S_KILL : S_IDLE;
            end
            S_KILL: begin
                kill_c  = 1'b1;
                state_d = S_WAIT_RELEASE;
            end
            S_WAIT_RELEASE: begin
                if (!i_obj1_active) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (i_wave_reset) begin
            state_d = S_IDLE;
            latch_c = 1'b0;
            kill_c  = 1'b0;
        end
    end

    // Kill strobes are decoded from the KILL state so a coincident wave
    // reset can still squash them in the same cycle.
    assign o_obj1_kill = kill_c;
    assign o_hit_pulse = kill_c;

    // Latched hit coordinates
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            row_q <= '0;
            col_q <= '0;
        end else if (latch_c) begin
            row_q <= i_hit_row;
            col_q <= i_hit_col;
        end
    end

    // Alive bitmap
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mask_q <= '1;
        end else if (i_wave_reset) begin
            mask_q <= '1;
        end else if (kill_c) begin
            mask_q[hit_idx_c] <= 1'b0;
        end
    end

    // Score; a clear beats a simultaneous kill
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            score_q <= '0;
        end else if (i_score_clear) begin
            score_q <= '0;
        end else if (kill_c) begin
            score_q <= score_inc_c;
        end
    end

    // Wave clear follows the committed mask one cycle later
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wave_clear_q <= 1'b0;
        end else if (i_wave_reset) begin
            wave_clear_q <= 1'b0;
        end else begin
            wave_clear_q <= (mask_q == '0);
        end
    end

    assign o_alive_mask = mask_q;
    assign o_score      = score_q;
    assign o_wave_clear = wave_clear_q;

`ifdef HIT_EXPLODE_EN
    localparam int unsigned EXP_W = $clog2(EXPLODE_FRAMES + 1);

    logic [EXP_W-1:0] exp_cnt_q;
    logic             exp_active_q;
    logic [ROW_W-1:0] exp_row_q;
    logic [COL_W-1:0] exp_col_q;

    // Explosion marker: a new kill restarts the frame countdown
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            exp_cnt_q    <= '0;
            exp_active_q <= 1'b0;
            exp_row_q    <= '0;
            exp_col_q    <= '0;
        end else if (i_wave_reset) begin
            exp_cnt_q    <= '0;
            exp_active_q <= 1'b0;
            exp_row_q    <= '0;
            exp_col_q    <= '0;
        end else if (kill_c) begin
            exp_cnt_q    <= EXP_W'(EXPLODE_FRAMES);
            exp_active_q <= 1'b1;
            exp_row_q    <= row_q;
            exp_col_q    <= col_q;
        end else if (i_frame_tick && exp_active_q) begin
            if (exp_cnt_q <= EXP_W'(1)) begin
                exp_cnt_q    <= '0;
                exp_active_q <= 1'b0;
            end else begin
                exp_cnt_q <= exp_cnt_q - EXP_W'(1);
            end
        end
    end

    assign o_explode_active = exp_active_q;
    assign o_explode_row    = exp_row_q;
    assign o_explode_col    = exp_col_q;
`else
    logic unused_explode;

    assign unused_explode   = i_frame_tick | (EXPLODE_FRAMES == 0);
    assign o_explode_active = 1'b0;
    assign o_explode_row    = '0;
    assign o_explode_col    = '0;
`endif

endmodule

// File: tb/tb_hit_resolver.sv
// Self-checking bench for hit_resolver: directed scenarios plus randomized
// shots checked against a bitmap/score reference model, with a scoreboard
// monitor consuming every kill pulse the DUT emits.
module tb_hit_resolver;

    localparam int unsigned ROWS   = 3;
    localparam int unsigned COLS   = 8;
    localparam int unsigned CELLS  = 24;
    localparam int unsigned POINTS = 10;
    localparam int          SMAX   = 65535;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_collision_detected;
    logic [2:0]  i_hit_row;
    logic [3:0]  i_hit_col;
    logic        i_obj1_active;
    logic        i_wave_reset;
    logic        i_score_clear;
    logic        i_frame_tick;
    logic [2:0]  i_query_row;
    logic [3:0]  i_query_col;
    logic        o_query_alive;
    logic [23:0] o_alive_mask;
    logic        o_obj1_kill;
    logic        o_hit_pulse;
    logic [15:0] o_score;
    logic        o_wave_clear;
    logic        o_explode_active;
    logic [2:0]  o_explode_row;
    logic [3:0]  o_explode_col;

    hit_resolver #(
        .GRID_ROWS(3), .GRID_COLS(8), .POINTS(10), .SCORE_W(16), .EXPLODE_FRAMES(8)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_collision_detected(i_collision_detected),
        .i_hit_row(i_hit_row), .i_hit_col(i_hit_col),
        .i_obj1_active(i_obj1_active),
        .i_wave_reset(i_wave_reset), .i_score_clear(i_score_clear),
        .i_frame_tick(i_frame_tick),
        .i_query_row(i_query_row), .i_query_col(i_query_col),
        .o_query_alive(o_query_alive), .o_alive_mask(o_alive_mask),
        .o_obj1_kill(o_obj1_kill), .o_hit_pulse(o_hit_pulse),
        .o_score(o_score), .o_wave_clear(o_wave_clear),
        .o_explode_active(o_explode_active),
        .o_explode_row(o_explode_row), .o_explode_col(o_explode_col)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    typedef struct packed {
        logic [23:0] mask;
        logic [15:0] score;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        cur;
    bit          pending = 1'b0;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [23:0] m_mask;
    int          m_score;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Scoreboard monitor: each kill pulse consumes one expected kill; the
    // committed score and mask are checked one cycle later.
    always @(negedge i_clk) begin
        #1;
        if (i_rst_n) begin
            if (pending) begin
                check("sb_score", 32'(o_score), 32'(cur.score));
                check("sb_mask", 32'(o_alive_mask), 32'(cur.mask));
                pending = 1'b0;
            end
            if (o_hit_pulse || o_obj1_kill) begin
                check("kill_eq_hit", 32'(o_obj1_kill), 32'(o_hit_pulse));
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_kill: got pulse expected none at %0t", $time);
                end else begin
                    cur     = sb_q.pop_front();
                    pending = 1'b1;
                end
            end
        end
    end

    function automatic bit model_alive(input int r, input int c);
        if (r < int'(ROWS) && c < int'(COLS)) return m_mask[r*COLS+c];
        return 1'b0;
    endfunction

    // One projectile: collision from cycle 0 for h cycles, release afterwards.
    // mode 1: score clear in the KILL cycle; mode 2: wave reset in the KILL cycle.
    task automatic shot(input int r, input int c, input int h, input int mode);
        bit hit;
        int cnt;
        int first_k;
        int qr;
        int qc;
        hit = model_alive(r, c);
        if (mode == 2) begin
            m_mask = '1;
        end else if (hit) begin
            m_mask[r*COLS+c] = 1'b0;
            m_score = (m_score + int'(POINTS) > SMAX) ? SMAX : m_score + int'(POINTS);
        end
        if (mode == 1) m_score = 0;
        if (hit && mode != 2) sb_q.push_back({m_mask, 16'(m_score)});
        cnt     = 0;
        first_k = 0;
        @(negedge i_clk);
        i_collision_detected = 1'b1;
        i_hit_row            = 3'(r);
        i_hit_col            = 4'(c);
        i_obj1_active        = 1'b1;
        for (int k = 1; k <= h + 3; k++) begin
            @(negedge i_clk);
            if (k == h) i_collision_detected = 1'b0;
            i_wave_reset  = (mode == 2 && k == 2);
            i_score_clear = (mode == 1 && k == 2);
            #1;
            if (o_hit_pulse) begin
                cnt++;
                if (first_k == 0) first_k = k;
            end
        end
        i_obj1_active = 1'b0;
        @(negedge i_clk);
        qr = $urandom_range(0, 7);
        qc = $urandom_range(0, 15);
        i_query_row = 3'(qr);
        i_query_col = 4'(qc);
        #1;
        check("kill_timing", 32'(cnt * 16 + first_k), (hit && mode != 2) ? 32'd18 : 32'd0);
        check("mask", 32'(o_alive_mask), 32'(m_mask));
        check("score", 32'(o_score), 32'(m_score));
        check("wave_clear", 32'(o_wave_clear), 32'(m_mask == '0));
        check("query", 32'(o_query_alive), 32'(model_alive(qr, qc)));
`ifndef HIT_EXPLODE_EN
        check("explode_off", {28'd0, o_explode_active, o_explode_row}, 32'd0);
`endif
    endtask

    task automatic reset_grid(input bit sc);
        @(negedge i_clk);
        i_wave_reset  = 1'b1;
        i_score_clear = sc;
        @(negedge i_clk);
        i_wave_reset  = 1'b0;
        i_score_clear = 1'b0;
        #1;
        m_mask = '1;
        if (sc) m_score = 0;
        check("wr_mask", 32'(o_alive_mask), 32'h00FFFFFF);
        check("wr_wave_clear", 32'(o_wave_clear), 32'd0);
        check("wr_score", 32'(o_score), 32'(m_score));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int r;
        int c;
        int mode;
        int h;
        i_rst_n = 1'b0;
        i_collision_detected = 1'b0;
        i_hit_row = '0;
        i_hit_col = '0;
        i_obj1_active = 1'b0;
        i_wave_reset = 1'b0;
        i_score_clear = 1'b0;
        i_frame_tick = 1'b0;
        i_query_row = 3'd2;
        i_query_col = 4'd7;
        m_mask = '1;
        m_score = 0;
        repeat (2) @(negedge i_clk);
        #1;
        check("rst_mask", 32'(o_alive_mask), 32'h00FFFFFF);
        check("rst_score", 32'(o_score), 32'd0);
        check("rst_query_2_7", 32'(o_query_alive), 32'd1);
        check("rst_pulses", {28'd0, o_obj1_kill, o_hit_pulse, o_wave_clear, o_explode_active}, 32'd0);
        i_query_row = 3'd3;
        i_query_col = 4'd0;
        #1;
        check("query_oob_row", 32'(o_query_alive), 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // First kill, then a held collision, dead-slot retry, out of range
        shot(1, 3, 1, 0);
        check("bit11_dead", 32'(o_alive_mask[11]), 32'd0);
        reset_grid(1'b1);
        shot(1, 3, 20, 0);
        check("held_score", 32'(o_score), 32'd10);
        shot(1, 3, 5, 0);
        shot(3, 0, 1, 0);
        shot(0, 9, 1, 0);

        // Clear the whole wave
        reset_grid(1'b1);
        for (int n = 0; n < int'(CELLS); n++) shot(n / 8, n % 8, 1, 0);
        check("wave_score", 32'(o_score), 32'd240);
        check("wave_clear_set", 32'(o_wave_clear), 32'd1);
        reset_grid(1'b0);

        // Clear/reset coincident with the KILL cycle
        shot(0, 0, 1, 1);
        shot(0, 1, 1, 2);
        shot(0, 2, 1, 0);

`ifdef HIT_EXPLODE_EN
        reset_grid(1'b0);
        shot(0, 5, 1, 0);
        check("exp_active", 32'(o_explode_active), 32'd1);
        check("exp_row", 32'(o_explode_row), 32'd0);
        check("exp_col", 32'(o_explode_col), 32'd5);
        for (int t = 1; t <= 8; t++) begin
            @(negedge i_clk);
            i_frame_tick = 1'b1;
            @(negedge i_clk);
            i_frame_tick = 1'b0;
            #1;
            check("exp_hold", 32'(o_explode_active), 32'(t < 8));
        end
`endif

        // Randomized shots against the model
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 3);
            c = $urandom_range(0, 9);
            mode = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0;
            h = (mode == 0) ? int'($urandom_range(1, 4)) : 1;
            shot(r, c, h, mode);
            if (m_mask == '0) reset_grid(1'($urandom_range(0, 1)));
        end

        // Drive score into saturation
        reset_grid(1'b1);
        for (int n = 0; n < 6555; n++) begin
            if (n > 0 && n % 24 == 0) reset_grid(1'b0);
            shot((n % 24) / 8, n % 8, 1, 0);
        end
        check("score_saturated", 32'(o_score), 32'h0000FFFF);

        // Asynchronous reset mid-resolution
        reset_grid(1'b0);
        @(negedge i_clk);
        i_collision_detected = 1'b1;
        i_hit_row = 3'd2;
        i_hit_col = 4'd4;
        i_obj1_active = 1'b1;
        @(negedge i_clk);
        i_collision_detected = 1'b0;
        i_obj1_active = 1'b0;
        #2 i_rst_n = 1'b0;
        #1;
        check("arst_mask", 32'(o_alive_mask), 32'h00FFFFFF);
        check("arst_score", 32'(o_score), 32'd0);
        check("arst_pulses", {29'd0, o_hit_pulse, o_wave_clear, o_explode_active}, 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        m_mask = '1;
        m_score = 0;
        shot(2, 7, 1, 0);

        repeat (3) @(negedge i_clk);
        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
